// File: rtl/banco_de_registradores_param.sv
// Parametrised register file with per-register busy scoreboard.
// Combinational reads with optional write-to-read bypass.
module banco_de_registradores_param #(
  parameter int LARGURA  = 32,
  parameter int N_REGS   = 32,
  parameter int END_W    = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [END_W-1:0]   rl1,
  input  logic [END_W-1:0]   rl2,
  input  logic [END_W-1:0]   resc,
  input  logic [LARGURA-1:0] dado,
  input  logic               h_esc,
  input  logic [END_W-1:0]   res_reserva,
  input  logic               h_reserva,
  output logic [LARGURA-1:0] d1,
  output logic [LARGURA-1:0] d2,
  output logic               ocupado1,
  output logic               ocupado2,
  output logic               pronto
);

  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic [LARGURA-1:0] r_x [N_REGS];
  logic [N_REGS-1:0]  r_b;
  logic [N_REGS-1:0]  w_b_nxt;
  logic               w_we;
  logic               w_z1;
  logic               w_z2;
  logic               w_fw1;
  logic               w_fw2;

  // x0 swallows writes when hardwired to zero
  assign w_we = h_esc && !(ZR && (resc == '0));

  // next busy vector: release first, reservation overrides
  always_comb begin
    w_b_nxt = r_b;
    if (h_esc)
      w_b_nxt[resc] = 1'b0;
    if (h_reserva)
      w_b_nxt[res_reserva] = 1'b1;
    if (ZR)
      w_b_nxt[0] = 1'b0;
  end

  // storage and scoreboard state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REGS; i++)
        r_x[i] <= '0;
      r_b <= '0;
    end else begin
      if (w_we)
        r_x[resc] <= dado;
      r_b <= w_b_nxt;
    end
  end

  // forwarding is suppressed while reset holds outputs low
  always_comb begin
    w_z1  = ZR && (rl1 == '0);
    w_fw1 = BP && rst_n && h_esc &&
            (rl1 == resc) && !w_z1;
    d1 = r_x[rl1];
    if (w_fw1)
      d1 = dado;
    if (w_z1)
      d1 = '0;
    ocupado1 = r_b[rl1] && !w_fw1;
  end

  // read port 2, same rules as port 1
  always_comb begin
    w_z2  = ZR && (rl2 == '0);
    w_fw2 = BP && rst_n && h_esc &&
            (rl2 == resc) && !w_z2;
    d2 = r_x[rl2];
    if (w_fw2)
      d2 = dado;
    if (w_z2)
      d2 = '0;
    ocupado2 = r_b[rl2] && !w_fw2;
  end

  assign pronto = !ocupado1 && !ocupado2;

endmodule

// File: doc/banco_de_registradores_param.md
Name: banco_de_registradores_param

Overview:
- Parametrised successor of the 32-bit register file for the RISC-V core.
- Storage width, register count, x0 handling and write-to-read bypass are all configurable.
- Has an asynchronous active-low reset that clears all storage.
- Adds a per-register scoreboard (busy bits): issue reserves a destination, writeback releases it, and the decode stage reads hazard status per source operand.

Parameters:
LARGURA, 32, data width of every register in bits
N_REGS, 32, number of architectural registers (power of 2, >=2)
END_W, 5, address width; must equal $clog2(N_REGS)
ZERO_REG, 1, 1: register 0 reads 0, ignores writes and reservations
BYPASS, 1, 1: same-cycle write data forwarded to read ports and busy outputs

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
rl1  input  END_W  read address, port 1
rl2  input  END_W  read address, port 2
resc  input  END_W  write address
dado  input  LARGURA  write data
h_esc  input  1  write enable (writeback); also releases busy bit of resc
res_reserva  input  END_W  destination register to reserve (issue)
h_reserva  input  1  reservation enable
d1  output  LARGURA  read data, port 1 (combinational)
d2  output  LARGURA  read data, port 2 (combinational)
ocupado1  output  1  rl1 has a pending producer
ocupado2  output  1  rl2 has a pending producer
pronto  output  1  ~ocupado1 & ~ocupado2

Behaviour:
- Reset (rst_n=0, asynchronous, independent of clk):
  - All N_REGS registers cleared to 0; all busy bits cleared.
  - While held: d1=d2=0, ocupado1=ocupado2=0, pronto=1.
  - Release is synchronous in effect: first update on the first rising edge with rst_n=1.
- Write: on posedge with h_esc=1, x[resc] <= dado, unless ZERO_REG=1 and resc=0.
- Read, combinational, zero latency:
  - d1 = x[rl1].
  - If BYPASS=1, h_esc=1 and rl1==resc (and not the ZERO_REG x0 case), d1 = dado.
  - If ZERO_REG=1 and rl1=0, d1 = 0 regardless of other inputs.
  - d2 follows the same rules with rl2.
- Scoreboard, per register busy bit b[i], updated on posedge:
  - Set when h_reserva=1 and res_reserva=i.
  - Cleared when h_esc=1 and resc=i.
  - Both in the same cycle on the same i: set wins. The newer producer owns the register; the old value is still written.
  - ZERO_REG=1: b[0] is constantly 0.
  - Reserving an already-busy register keeps it busy; no count is kept, so a single writeback frees it.
  - Writing a non-busy register is legal: data is written, the bit stays 0.
- Busy outputs:
  - ocupado1 = b[rl1], except it is 0 when BYPASS=1, h_esc=1 and resc==rl1 (the data is forwarded this cycle).
  - A same-cycle reservation does not affect ocupado1/2 until the next cycle.
  - ocupado2 follows the same rules with rl2.
- Addresses >= N_REGS: only reachable if N_REGS is not a power of 2, which is illegal; behaviour undefined.
- No other internal state; latency of write to visible read is 1 cycle (0 with BYPASS).

Test Plan:
- Reset: drive rst_n=0 mid-simulation after writing x5=0xDEADBEEF. Required: immediately d1=0 with rl1=5, and after release x5 still reads 0 with pronto=1.
- Write/read:
  - Write x7=0x12345678 with BYPASS=0. Required: d1 shows the old value in the write cycle and 0x12345678 the cycle after.
  - Same stimulus with BYPASS=1. Required: d1 = 0x12345678 in the write cycle.
- x0:
  - ZERO_REG=1: write x0=0xFFFFFFFF and reserve x0. Required: d1=0, ocupado1=0 always.
  - ZERO_REG=0: the same write reads back 0xFFFFFFFF.
- Scoreboard:
  - Reserve x3, then set rl2=3. Required: ocupado2=1 and pronto=0.
  - Writeback x3=0xA5 with BYPASS=1. Required: ocupado2=0 and d2=0xA5 in that cycle, with the bit clear the following cycle.
- Simultaneous:
  - In one cycle, write x4 and reserve x4. Required: x4 holds the new data, and b[4]=1 afterwards.
  - In one cycle, reserve x4 and write x6. Required: both take effect independently.
- Dual read conflict: rl1=rl2=9 with x9 busy. Required: ocupado1=ocupado2=1, both ports return the same value.
